// File: rtl/tl_memory_if.sv
// EX/MEM -> MEM/WB bundle for the MEM pipeline stage.
// master = upstream driver (EX/MEM latch), slave = tl_memory.
interface tl_memory_if #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9
);
    logic                            i_alu_zero;
    logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg;
    logic [NB_CTRL_WB-1:0]           i_ctrl_wb;
    logic [NB_CTRL_MEM-1:0]          i_ctrl_mem;
    logic [LEN-1:0]                  i_pc_branch;
    logic [LEN-1:0]                  i_alu_result;
    logic [LEN-1:0]                  i_dato2;

    logic                            o_pc_src;
    logic [LEN-1:0]                  o_pc_branch;
    logic [LEN-1:0]                  o_rd_mem_corto;
    logic [LEN-1:0]                  o_read_data;
    logic [LEN-1:0]                  o_alu_result;
    logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg;
    logic [NB_CTRL_WB-1:0]           o_ctrl_wb;
    logic                            o_misaligned;

    modport master (
        output i_alu_zero, i_write_reg, i_ctrl_wb, i_ctrl_mem,
               i_pc_branch, i_alu_result, i_dato2,
        input  o_pc_src, o_pc_branch, o_rd_mem_corto, o_read_data,
               o_alu_result, o_write_reg, o_ctrl_wb, o_misaligned
    );

    modport slave (
        input  i_alu_zero, i_write_reg, i_ctrl_wb, i_ctrl_mem,
               i_pc_branch, i_alu_result, i_dato2,
        output o_pc_src, o_pc_branch, o_rd_mem_corto, o_read_data,
               o_alu_result, o_write_reg, o_ctrl_wb, o_misaligned
    );
endinterface

// File: rtl/tl_memory.sv
// MIPS MEM stage: byte/half/word loads and stores on a lane-split data RAM,
// branch resolution and the falling-edge MEM/WB latch. Optional: MEM_DEBUG_PORT_EN.
module tl_memory #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_ADDR_MEM          = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    tl_memory_if.slave             bus
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDR_MEM-1:0] i_dbg_addr,
    output logic [LEN-1:0]         o_dbg_data
`endif
);
    localparam int DEPTH    = 1 << NB_ADDR_MEM;
    localparam int NB_LANES = LEN / 8;

    logic [NB_ADDR_MEM-1:0] word_idx;
    logic [1:0]             lane;
    logic                   mem_read;
    logic                   mem_write;
    logic                   is_unsigned;
    logic [1:0]             size;

    logic                   misaligned_next;
    logic [NB_LANES-1:0]    lane_we;
    logic [LEN-1:0]         wr_data;
    logic [LEN-1:0]         rd_word;
    logic [7:0]             sel_byte;
    logic [15:0]            sel_half;
    logic [LEN-1:0]         load_val;
    logic [LEN-1:0]         read_data_next;
    logic [NB_CTRL_WB-1:0]  ctrl_wb_next;

    logic [LEN-1:0]                  read_data_reg;
    logic [LEN-1:0]                  alu_result_reg;
    logic [NB_ADDRESS_REGISTROS-1:0] write_reg_reg;
    logic [NB_CTRL_WB-1:0]           ctrl_wb_reg;
    logic                            misaligned_reg;

    // Upper address bits wrap and ctrl_mem[8:7] is reserved.
    logic unused_bits;
    assign unused_bits = ^{bus.i_alu_result[LEN-1:NB_ADDR_MEM+2], bus.i_ctrl_mem[8:7]};

    assign word_idx    = bus.i_alu_result[NB_ADDR_MEM+1:2];
    assign lane        = bus.i_alu_result[1:0];
    assign mem_read    = bus.i_ctrl_mem[0];
    assign mem_write   = bus.i_ctrl_mem[1];
    assign is_unsigned = bus.i_ctrl_mem[4];
    assign size        = bus.i_ctrl_mem[6:5];

    assign bus.o_pc_src       = (bus.i_ctrl_mem[2] & bus.i_alu_zero) |
                                (bus.i_ctrl_mem[3] & ~bus.i_alu_zero);
    assign bus.o_pc_branch    = bus.i_pc_branch;
    assign bus.o_rd_mem_corto = bus.i_alu_result;

    always_comb begin
        misaligned_next = 1'b0;
        if (mem_read | mem_write) begin
            case (size)
                2'b00:   misaligned_next = 1'b0;
                2'b01:   misaligned_next = lane[0];
                2'b11:   misaligned_next = |lane;
                default: misaligned_next = 1'b1;
            endcase
        end
    end

    // Store data is replicated across lanes so each lane RAM just picks its own byte.
    always_comb begin
        lane_we = '0;
        wr_data = bus.i_dato2;
        case (size)
            2'b00: begin
                lane_we = NB_LANES'(1) << lane;
                wr_data = {NB_LANES{bus.i_dato2[7:0]}};
            end
            2'b01: begin
                lane_we = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {(NB_LANES/2){bus.i_dato2[15:0]}};
            end
            default: lane_we = '1;
        endcase
        if (!mem_write || misaligned_next || i_rst) begin
            lane_we = '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB_LANES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(negedge i_clk) begin
                if (lane_we[gi]) begin
                    lane_mem[word_idx] <= wr_data[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
`ifdef MEM_DEBUG_PORT_EN
            assign o_dbg_data[gi*8 +: 8] = lane_mem[i_dbg_addr];
`endif
        end
    endgenerate

    always_comb begin
        sel_byte = rd_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_val = is_unsigned ? {{(LEN-8){1'b0}}, sel_byte}
                                            : {{(LEN-8){sel_byte[7]}}, sel_byte};
            2'b01:   load_val = is_unsigned ? {{(LEN-16){1'b0}}, sel_half}
                                            : {{(LEN-16){sel_half[15]}}, sel_half};
            default: load_val = rd_word;
        endcase
        read_data_next = (mem_read && !mem_write && !misaligned_next) ? load_val : '0;
        ctrl_wb_next   = misaligned_next ? '0 : bus.i_ctrl_wb;
    end

    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            read_data_reg  <= '0;
            alu_result_reg <= '0;
            write_reg_reg  <= '0;
            ctrl_wb_reg    <= '0;
            misaligned_reg <= 1'b0;
        end else begin
            read_data_reg  <= read_data_next;
            alu_result_reg <= bus.i_alu_result;
            write_reg_reg  <= bus.i_write_reg;
            ctrl_wb_reg    <= ctrl_wb_next;
            misaligned_reg <= misaligned_next;
        end
    end

    assign bus.o_read_data  = read_data_reg;
    assign bus.o_alu_result = alu_result_reg;
    assign bus.o_write_reg  = write_reg_reg;
    assign bus.o_ctrl_wb    = ctrl_wb_reg;
    assign bus.o_misaligned = misaligned_reg;
endmodule

// File: tb/tb_tl_memory.sv
// Self-checking bench for tl_memory: byte-array reference model, vector table,
// hand-written test-plan sequences and randomized traffic.
module tb_tl_memory;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_X = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0]  dbg_addr = 8'h00;
    logic [31:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [0:1023];

    logic [31:0] last_rd;
    logic        last_mis;
    logic [1:0]  last_wb;
    logic        last_pc_src;

    tl_memory_if bus ();

    tl_memory dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
`ifdef MEM_DEBUG_PORT_EN
        ,
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
`endif
    );

`ifndef MEM_DEBUG_PORT_EN
    assign dbg_data = 32'h0;
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] mk(input logic rd, input logic wr, input logic beq,
                                      input logic bne, input logic uns, input logic [1:0] sz);
        return {2'b00, sz, uns, bne, beq, wr, rd};
    endfunction

    // One pipeline slot: drive after posedge, check comb outputs, predict and check after negedge.
    task automatic step(input logic r, input logic [8:0] cm, input logic zero,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wreg, input logic [1:0] wb, input logic [31:0] pcb);
        logic [9:0]  a;
        logic [1:0]  sz;
        logic        rd, wr, uns, mis, exp_pc;
        int          n;
        logic [31:0] exp_rd, v;
        @(posedge clk);
        #1;
        rst              = r;
        bus.i_ctrl_mem   = cm;
        bus.i_alu_zero   = zero;
        bus.i_alu_result = addr;
        bus.i_dato2      = data;
        bus.i_write_reg  = wreg;
        bus.i_ctrl_wb    = wb;
        bus.i_pc_branch  = pcb;
        #1;
        exp_pc = zero ? cm[2] : cm[3];
        last_pc_src = bus.o_pc_src;
        chk("pc_src", {31'b0, bus.o_pc_src}, {31'b0, exp_pc});
        chk("pc_branch", bus.o_pc_branch, pcb);
        chk("rd_mem_corto", bus.o_rd_mem_corto, addr);

        a   = addr[9:0];
        rd  = cm[0];
        wr  = cm[1];
        uns = cm[4];
        sz  = cm[6:5];
        n   = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : 4;
        mis = (rd || wr) && ((sz == SZ_X) || (sz == SZ_H && a[0]) ||
                             (sz == SZ_W && a[1:0] != 2'b00));
        exp_rd = 32'h0;
        if (!r && rd && !wr && !mis) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + 10'(k)]) << (8 * k));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            exp_rd = v;
        end

        @(negedge clk);
        #1;
        last_rd  = bus.o_read_data;
        last_mis = bus.o_misaligned;
        last_wb  = bus.o_ctrl_wb;
        chk("read_data", bus.o_read_data, exp_rd);
        chk("alu_result", bus.o_alu_result, r ? 32'h0 : addr);
        chk("write_reg", {27'b0, bus.o_write_reg}, r ? 32'h0 : {27'b0, wreg});
        chk("ctrl_wb", {30'b0, bus.o_ctrl_wb}, (r || mis) ? 32'h0 : {30'b0, wb});
        chk("misaligned", {31'b0, bus.o_misaligned}, {31'b0, (!r && mis)});

        if (!r && wr && !mis) begin
            for (int k = 0; k < n; k++) ref_mem[a + 10'(k)] = data[8*k +: 8];
        end
    endtask

    task automatic op(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data);
        step(1'b0, mk(rd, wr, 1'b0, 1'b0, uns, sz), 1'b0, addr, data, 5'd7, 2'b11, 32'h0);
    endtask

    typedef struct {
        logic [8:0]  cm;
        logic        zero;
        logic [31:0] addr;
        logic        exp_pc_src;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{mk(0,0,1,0,0,SZ_W), 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{mk(0,0,1,0,0,SZ_W), 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[2] = '{mk(0,0,0,1,0,SZ_W), 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{mk(0,0,0,1,0,SZ_W), 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{mk(1,0,0,0,0,SZ_H), 1'b0, 32'h0000_0031, 1'b0, 1'b1};
        vecs[5] = '{mk(1,0,0,0,0,SZ_W), 1'b0, 32'h0000_0032, 1'b0, 1'b1};
        vecs[6] = '{mk(1,0,0,0,0,SZ_X), 1'b0, 32'h0000_0040, 1'b0, 1'b1};
        vecs[7] = '{mk(1,0,0,0,0,SZ_B), 1'b1, 32'h0000_0033, 1'b0, 1'b0};
        vecs[8] = '{mk(1,0,1,0,1,SZ_H), 1'b1, 32'h0000_0032, 1'b1, 1'b0};
        vecs[9] = '{mk(0,0,0,0,0,SZ_X), 1'b0, 32'h0000_0003, 1'b0, 1'b0};

        bus.i_ctrl_mem = '0; bus.i_alu_zero = 1'b0; bus.i_alu_result = '0;
        bus.i_dato2 = '0; bus.i_write_reg = '0; bus.i_ctrl_wb = '0; bus.i_pc_branch = '0;

        // Reset state
        step(1'b1, 9'h0, 1'b0, 32'h0, 32'h0, 5'd3, 2'b11, 32'h0);
        step(1'b1, 9'h0, 1'b0, 32'h4, 32'h0, 5'd9, 2'b01, 32'h0);

        // Bring RAM into a known state
        for (int w = 0; w < 256; w++) op(1'b0, 1'b1, 1'b0, SZ_W, 32'(w * 4), $urandom);

        // Word store/load
        op(0, 1, 0, SZ_W, 32'h10, 32'hDEAD_BEEF);
        op(1, 0, 0, SZ_W, 32'h10, 32'h0);
        chk("lw_0x10", last_rd, 32'hDEAD_BEEF);
        chk("lw_0x10_mis", {31'b0, last_mis}, 32'h0);
`ifdef MEM_DEBUG_PORT_EN
        dbg_addr = 8'h04;
        #1;
        chk("dbg_word4", dbg_data, 32'hDEAD_BEEF);
`endif

        // Byte store/loads
        op(0, 1, 0, SZ_W, 32'h20, 32'h1122_3344);
        op(0, 1, 0, SZ_B, 32'h21, 32'h0000_0080);
        op(1, 0, 0, SZ_B, 32'h21, 32'h0);
        chk("lb_0x21", last_rd, 32'hFFFF_FF80);
        op(1, 0, 1, SZ_B, 32'h21, 32'h0);
        chk("lbu_0x21", last_rd, 32'h0000_0080);
        op(1, 0, 0, SZ_W, 32'h20, 32'h0);
        chk("lw_0x20_lanes", last_rd, 32'h1122_8044);

        // Half store/loads and misaligned half
        op(0, 1, 0, SZ_W, 32'h30, 32'hAABB_CCDD);
        op(0, 1, 0, SZ_H, 32'h32, 32'h0000_1234);
        op(1, 0, 0, SZ_H, 32'h32, 32'h0);
        chk("lh_0x32", last_rd, 32'h0000_1234);
        op(1, 0, 0, SZ_W, 32'h30, 32'h0);
        chk("lw_0x30", last_rd, 32'h1234_CCDD);
        op(1, 0, 0, SZ_H, 32'h31, 32'h0);
        chk("lh_0x31_mis", {31'b0, last_mis}, 32'h1);
        chk("lh_0x31_wb", {30'b0, last_wb}, 32'h0);
        op(0, 1, 0, SZ_H, 32'h31, 32'h0000_FFFF);
        op(1, 0, 0, SZ_W, 32'h30, 32'h0);
        chk("lw_0x30_after_bad_sh", last_rd, 32'h1234_CCDD);

        // Vector table: branches and alignment
        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].cm, vecs[i].zero, vecs[i].addr, 32'h0, 5'd1, 2'b01, 32'h40);
            chk($sformatf("tbl%0d_pc_src", i), {31'b0, last_pc_src}, {31'b0, vecs[i].exp_pc_src});
            chk($sformatf("tbl%0d_mis", i), {31'b0, last_mis}, {31'b0, vecs[i].exp_mis});
        end

        // Address wrap
        op(0, 1, 0, SZ_W, 32'h400, 32'hCAFE_F00D);
        op(1, 0, 0, SZ_W, 32'h0, 32'h0);
        chk("lw_wrap", last_rd, 32'hCAFE_F00D);

        // Reset during store suppresses the write
        op(0, 1, 0, SZ_W, 32'h50, 32'h5555_AAAA);
        step(1'b1, mk(0,1,0,0,0,SZ_W), 1'b0, 32'h50, 32'h0BAD_F00D, 5'd4, 2'b11, 32'h0);
        op(1, 0, 0, SZ_W, 32'h50, 32'h0);
        chk("lw_after_rst_store", last_rd, 32'h5555_AAAA);

        // Read+write together acts as a store
        op(1, 1, 0, SZ_W, 32'h60, 32'h7777_8888);
        chk("rdwr_read_data", last_rd, 32'h0);
        op(1, 0, 0, SZ_W, 32'h60, 32'h0);
        chk("lw_after_rdwr", last_rd, 32'h7777_8888);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [8:0]  cm;
            logic [31:0] addr;
            cm = 9'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                cm[6:5] = (cm[6:5] == SZ_X) ? SZ_W : cm[6:5];
                addr[1:0] = 2'b00;
            end
            step(($urandom_range(0, 31) == 0), cm, 1'($urandom), addr, $urandom,
                 5'($urandom), 2'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
